pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RV32 core. It arbitrates stall requests from ID (load-use) and EXE (multi-cycle op), and PC redirects from EXE (jump/branch taken). It also sequences trap entry (ecall) and mret as a small multi-cycle FSM that issues CSR writes and redirects fetch. It sits beside the pipeline registers and drives their hold/bubble controls and the PC mux.

Parameters:
ADDR_WIDTH, 32, instruction address width
DATA_WIDTH, 32, CSR data width
STALL_TIMEOUT, 64, consecutive EXE-stall cycles before stall_timeout_o asserts

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
id_stallreq_i  in  1  load-use hazard from ID
exe_stallreq_i  in  1  EXE multi-cycle op busy
exe_jump_i  in  1  EXE resolved taken jump/branch
exe_jump_addr_i  in  ADDR_WIDTH  jump target
trap_req_i  in  1  EXE holds ecall
mret_req_i  in  1  EXE holds mret
trap_pc_i  in  ADDR_WIDTH  PC of trapping instruction
trap_cause_i  in  DATA_WIDTH  mcause value
mtvec_i  in  DATA_WIDTH  current mtvec
mepc_i  in  DATA_WIDTH  current mepc
mstatus_i  in  DATA_WIDTH  current mstatus
stall_o  out  5  hold: [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM, [4] MEM/WB
flush_o  out  3  bubble: [0] IF/ID, [1] ID/EXE, [2] EXE/MEM
new_pc_valid_o  out  1  PC redirect this cycle
new_pc_o  out  ADDR_WIDTH  redirect target
csr_we_o  out  1  CSR write strobe
csr_waddr_o  out  12  CSR address
csr_wdata_o  out  DATA_WIDTH  CSR write data
busy_o  out  1  FSM not IDLE
stall_timeout_o  out  1  sticky EXE-stall timeout flag
stall_cycles_o  out  32  count of cycles with stall_o[0]=1

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all outputs 0; captured pc/cause regs 0; counters 0.
- FSM states: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, M_MSTATUS, REDIRECT. Registered state; stall/flush/CSR/redirect outputs are Moore from state, except in IDLE, where they are combinational from inputs.
- IDLE priority, highest first:
  1. trap_req_i with exe_stallreq_i=0: capture trap_pc_i/trap_cause_i; next T_MEPC; stall_o=5'b11111, flush_o=3'b000 this cycle.
  2. mret_req_i with exe_stallreq_i=0: capture {mepc_i[31:2],2'b00} as target; next M_MSTATUS; stall_o=5'b11111.
  3. exe_jump_i: new_pc_valid_o=1, new_pc_o=exe_jump_addr_i, flush_o=3'b011, stall_o=0; same cycle, no stall.
  4. exe_stallreq_i: stall_o=5'b01111, flush_o=3'b100.
  5. id_stallreq_i: stall_o=5'b00011, flush_o=3'b010 (bubble into EXE).
  6. Otherwise all 0.
- If trap_req_i and mret_req_i are both set, trap wins. A jump in the same cycle as a trap/mret is dropped.
- T_MEPC: csr_we_o=1, addr 0x341, data=captured pc. Next T_MCAUSE.
- T_MCAUSE: addr 0x342, data=captured cause. Next T_MSTATUS.
- T_MSTATUS: addr 0x300, data=mstatus_i with bit7(MPIE)=bit3(MIE), bit3=0, bits[12:11]=2'b11. Target={mtvec_i[31:2],2'b00}. Next REDIRECT.
- M_MSTATUS: addr 0x300, data=mstatus_i with bit3=bit7, bit7=1. Next REDIRECT.
- In T_*/M_* states: stall_o=5'b01111, flush_o=3'b111.
- REDIRECT: new_pc_valid_o=1, new_pc_o=target, flush_o=3'b111, stall_o=0. Next IDLE.
- Trap latency: request cycle + 3 CSR cycles + redirect = 5 cycles. mret latency: 3 cycles.
- All request inputs are ignored outside IDLE; busy_o=1 outside IDLE.
- Timeout counter:
  - Increments while IDLE and exe_stallreq_i=1; clears when exe_stallreq_i=0.
  - Saturates at STALL_TIMEOUT.
  - On reaching STALL_TIMEOUT, sets stall_timeout_o (sticky until reset).
- stall_cycles_o: increments each cycle stall_o[0]=1; wraps 0xFFFFFFFF->0.
- Reset mid-FSM: immediate return to IDLE, csr_we_o drops. CSR writes already issued stand; no replay.

Decomposition:
- Shared defines get CSR addresses (CSR_MEPC 12'h341, CSR_MCAUSE 12'h342, CSR_MSTATUS 12'h300), stall/flush vector constants (STALL_NONE, STALL_LOADUSE, STALL_EXE, STALL_ALL, FLUSH_*), and FSM state encodings.
- One sub-module: pipe_ctrl_fsm, holding the trap/mret state machine and capture regs.
- Arbitration and counters stay in the top.

Test Plan:
- id_stallreq_i=1 for 1 cycle -> stall_o=5'b00011, flush_o=3'b010 that cycle; stall_cycles_o increments by 1.
- exe_stallreq_i=1 and id_stallreq_i=1 together -> stall_o=5'b01111, flush_o=3'b100; held 64 cycles -> stall_timeout_o=1 on the 64th and stays 1.
- exe_jump_i=1, addr 0x0000_0100 -> same cycle new_pc_valid_o=1, new_pc_o=0x100, flush_o=3'b011.
- trap_req_i, trap_pc_i=0x80, cause=11, mtvec_i=0x203, mstatus_i=0x8, plus exe_jump_i=1 in the same cycle -> jump dropped. CSR writes in order (0x341,0x80), (0x342,11), (0x300,0x1880). Then new_pc_o=0x200 at cycle 5; busy_o high for 4 cycles.
- mret_req_i, mepc_i=0x84, mstatus_i=0x80 -> (0x300,0x88) then new_pc_o=0x84; the following trap_req_i pulse during busy is ignored.
- rst_n_i low during T_MCAUSE -> outputs 0 asynchronously, state IDLE; the next trap_req_i restarts the full sequence at T_MEPC.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: CSR addresses, hold/bubble
// vectors and the trap/mret sequencer state encoding.
package pipe_ctrl_pkg;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    // Hold bits: [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM, [4] MEM/WB
    localparam logic [4:0] STALL_NONE    = 5'b00000;
    localparam logic [4:0] STALL_LOADUSE = 5'b00011;
    localparam logic [4:0] STALL_EXE     = 5'b01111;
    localparam logic [4:0] STALL_ALL     = 5'b11111;

    // Bubble bits: [0] IF/ID, [1] ID/EXE, [2] EXE/MEM
    localparam logic [2:0] FLUSH_NONE    = 3'b000;
    localparam logic [2:0] FLUSH_LOADUSE = 3'b010;
    localparam logic [2:0] FLUSH_JUMP    = 3'b011;
    localparam logic [2:0] FLUSH_EXE     = 3'b100;
    localparam logic [2:0] FLUSH_ALL     = 3'b111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        T_MEPC    = 3'd1,
        T_MCAUSE  = 3'd2,
        T_MSTATUS = 3'd3,
        M_MSTATUS = 3'd4,
        REDIRECT  = 3'd5
    } fsm_state_t;

endpackage

// File: rtl/pipe_ctrl_fsm.sv
// Trap-entry / mret sequencer: issues the CSR write sequence and the final
// fetch redirect. Outputs are meaningful only while busy is high.
module pipe_ctrl_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_trap,
    input  logic                  start_mret,
    input  logic [ADDR_WIDTH-1:0] trap_pc,
    input  logic [DATA_WIDTH-1:0] trap_cause,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    input  logic [DATA_WIDTH-1:0] mstatus,
    output logic                  busy,
    output logic [4:0]            stall,
    output logic [2:0]            flush,
    output logic                  new_pc_valid,
    output logic [ADDR_WIDTH-1:0] new_pc,
    output logic                  csr_we,
    output logic [11:0]           csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    fsm_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] cause_reg;
    logic [ADDR_WIDTH-1:0] target_reg;
    logic [DATA_WIDTH-1:0] mstatus_mod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            cause_reg  <= '0;
            target_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start_trap) begin
                pc_reg    <= trap_pc;
                cause_reg <= trap_cause;
            end
            // mret target is frozen at request time; trap target is read from mtvec late
            if (state_reg == IDLE && start_mret && !start_trap)
                target_reg <= ADDR_WIDTH'(mepc & ALIGN_MASK);
            if (state_reg == T_MSTATUS)
                target_reg <= ADDR_WIDTH'(mtvec & ALIGN_MASK);
        end
    end

    always_comb begin
        state_next   = state_reg;
        stall        = STALL_NONE;
        flush        = FLUSH_NONE;
        new_pc_valid = 1'b0;
        new_pc       = '0;
        csr_we       = 1'b0;
        csr_waddr    = 12'h000;
        csr_wdata    = '0;
        mstatus_mod  = mstatus;
        case (state_reg)
            IDLE: begin
                if (start_trap)      state_next = T_MEPC;
                else if (start_mret) state_next = M_MSTATUS;
            end
            T_MEPC: begin
                state_next = T_MCAUSE;
                stall      = STALL_EXE;
                flush      = FLUSH_ALL;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MEPC;
                csr_wdata  = DATA_WIDTH'(pc_reg);
            end
            T_MCAUSE: begin
                state_next = T_MSTATUS;
                stall      = STALL_EXE;
                flush      = FLUSH_ALL;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MCAUSE;
                csr_wdata  = cause_reg;
            end
            T_MSTATUS: begin
                state_next         = REDIRECT;
                stall              = STALL_EXE;
                flush              = FLUSH_ALL;
                mstatus_mod[7]     = mstatus[3];
                mstatus_mod[3]     = 1'b0;
                mstatus_mod[12:11] = 2'b11;
                csr_we             = 1'b1;
                csr_waddr          = CSR_MSTATUS;
                csr_wdata          = mstatus_mod;
            end
            M_MSTATUS: begin
                state_next     = REDIRECT;
                stall          = STALL_EXE;
                flush          = FLUSH_ALL;
                mstatus_mod[3] = mstatus[7];
                mstatus_mod[7] = 1'b1;
                csr_we         = 1'b1;
                csr_waddr      = CSR_MSTATUS;
                csr_wdata      = mstatus_mod;
            end
            REDIRECT: begin
                state_next   = IDLE;
                flush        = FLUSH_ALL;
                new_pc_valid = 1'b1;
                new_pc       = target_reg;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates stall/redirect requests while idle, hands
// trap/mret sequencing to pipe_ctrl_fsm, and keeps stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  id_stallreq_i,
    input  logic                  exe_stallreq_i,
    input  logic                  exe_jump_i,
    input  logic [ADDR_WIDTH-1:0] exe_jump_addr_i,
    input  logic                  trap_req_i,
    input  logic                  mret_req_i,
    input  logic [ADDR_WIDTH-1:0] trap_pc_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    input  logic [DATA_WIDTH-1:0] mstatus_i,
    output logic [4:0]            stall_o,
    output logic [2:0]            flush_o,
    output logic                  new_pc_valid_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  busy_o,
    output logic                  stall_timeout_o,
    output logic [31:0]           stall_cycles_o
);

    localparam int              CNT_W         = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(STALL_TIMEOUT);

    logic                  take_trap, take_mret;
    logic                  fsm_busy, fsm_new_pc_valid, fsm_csr_we;
    logic [4:0]            fsm_stall;
    logic [2:0]            fsm_flush;
    logic [ADDR_WIDTH-1:0] fsm_new_pc;
    logic [11:0]           fsm_csr_waddr;
    logic [DATA_WIDTH-1:0] fsm_csr_wdata;
    logic [CNT_W-1:0]      timeout_cnt_reg, timeout_cnt_next;
    logic                  stall_timeout_reg;
    logic [31:0]           stall_cycles_reg;

    // A trap or mret must wait until the multi-cycle EXE op has drained
    assign take_trap = trap_req_i & ~exe_stallreq_i;
    assign take_mret = mret_req_i & ~exe_stallreq_i & ~trap_req_i;

    pipe_ctrl_fsm #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fsm (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .start_trap  (take_trap),
        .start_mret  (take_mret),
        .trap_pc     (trap_pc_i),
        .trap_cause  (trap_cause_i),
        .mtvec       (mtvec_i),
        .mepc        (mepc_i),
        .mstatus     (mstatus_i),
        .busy        (fsm_busy),
        .stall       (fsm_stall),
        .flush       (fsm_flush),
        .new_pc_valid(fsm_new_pc_valid),
        .new_pc      (fsm_new_pc),
        .csr_we      (fsm_csr_we),
        .csr_waddr   (fsm_csr_waddr),
        .csr_wdata   (fsm_csr_wdata)
    );

    // Outputs are forced low while reset is held, even if requests are active
    always_comb begin
        stall_o        = STALL_NONE;
        flush_o        = FLUSH_NONE;
        new_pc_valid_o = 1'b0;
        new_pc_o       = '0;
        csr_we_o       = 1'b0;
        csr_waddr_o    = 12'h000;
        csr_wdata_o    = '0;
        if (rst_n_i) begin
            if (fsm_busy) begin
                stall_o        = fsm_stall;
                flush_o        = fsm_flush;
                new_pc_valid_o = fsm_new_pc_valid;
                new_pc_o       = fsm_new_pc;
                csr_we_o       = fsm_csr_we;
                csr_waddr_o    = fsm_csr_waddr;
                csr_wdata_o    = fsm_csr_wdata;
            end else if (take_trap || take_mret) begin
                stall_o = STALL_ALL;
            end else if (exe_jump_i) begin
                new_pc_valid_o = 1'b1;
                new_pc_o       = exe_jump_addr_i;
                flush_o        = FLUSH_JUMP;
            end else if (exe_stallreq_i) begin
                stall_o = STALL_EXE;
                flush_o = FLUSH_EXE;
            end else if (id_stallreq_i) begin
                stall_o = STALL_LOADUSE;
                flush_o = FLUSH_LOADUSE;
            end
        end
    end

    always_comb begin
        timeout_cnt_next = timeout_cnt_reg;
        if (!exe_stallreq_i)
            timeout_cnt_next = '0;
        else if (!fsm_busy && timeout_cnt_reg != TIMEOUT_LIMIT)
            timeout_cnt_next = timeout_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timeout_cnt_reg   <= '0;
            stall_timeout_reg <= 1'b0;
            stall_cycles_reg  <= 32'd0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_next;
            if (timeout_cnt_next == TIMEOUT_LIMIT)
                stall_timeout_reg <= 1'b1;
            if (stall_o[0])
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign busy_o          = fsm_busy;
    assign stall_timeout_o = stall_timeout_reg;
    assign stall_cycles_o  = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle arbitration vectors
// followed by hand-written trap, mret, mid-sequence reset and timeout runs.
module tb_pipe_ctrl;

    logic        clk_i;
    logic        rst_n_i;
    logic        id_stallreq_i, exe_stallreq_i, exe_jump_i;
    logic [31:0] exe_jump_addr_i;
    logic        trap_req_i, mret_req_i;
    logic [31:0] trap_pc_i, trap_cause_i, mtvec_i, mepc_i, mstatus_i;
    logic [4:0]  stall_o;
    logic [2:0]  flush_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        busy_o, stall_timeout_o;
    logic [31:0] stall_cycles_o;

    int total = 0;
    int bad   = 0;
    int sc_exp;

    pipe_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STALL_TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_stallreq_i(id_stallreq_i), .exe_stallreq_i(exe_stallreq_i),
        .exe_jump_i(exe_jump_i), .exe_jump_addr_i(exe_jump_addr_i),
        .trap_req_i(trap_req_i), .mret_req_i(mret_req_i),
        .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
        .stall_o(stall_o), .flush_o(flush_o),
        .new_pc_valid_o(new_pc_valid_o), .new_pc_o(new_pc_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .busy_o(busy_o), .stall_timeout_o(stall_timeout_o), .stall_cycles_o(stall_cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        id, exe, jump, trap, mret;
        logic [31:0] jaddr;
        logic [4:0]  stall;
        logic [2:0]  flush;
        logic        npv;
        logic [31:0] npc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic id, input logic exe, input logic jump,
                                input logic trap, input logic mret, input logic [31:0] jaddr,
                                input logic [4:0] s, input logic [2:0] f,
                                input logic npv, input logic [31:0] npc);
        vec_t v;
        v.id = id; v.exe = exe; v.jump = jump; v.trap = trap; v.mret = mret;
        v.jaddr = jaddr; v.stall = s; v.flush = f; v.npv = npv; v.npc = npc;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_req();
        id_stallreq_i  = 1'b0;
        exe_stallreq_i = 1'b0;
        exe_jump_i     = 1'b0;
        trap_req_i     = 1'b0;
        mret_req_i     = 1'b0;
    endtask

    task automatic chk(input string name, input logic [4:0] s, input logic [2:0] f,
                       input logic v, input logic [31:0] pc, input logic we,
                       input logic [11:0] a, input logic [31:0] d, input logic b);
        total++;
        if (stall_o !== s || flush_o !== f || new_pc_valid_o !== v || new_pc_o !== pc ||
            csr_we_o !== we || csr_waddr_o !== a || csr_wdata_o !== d || busy_o !== b) begin
            bad++;
            $display("FAIL %s: got stall=%b flush=%b npv=%b npc=%h we=%b addr=%h data=%h busy=%b; want stall=%b flush=%b npv=%b npc=%h we=%b addr=%h data=%h busy=%b",
                     name, stall_o, flush_o, new_pc_valid_o, new_pc_o, csr_we_o, csr_waddr_o,
                     csr_wdata_o, busy_o, s, f, v, pc, we, a, d, b);
        end else begin
            $display("ok   %s: stall=%b flush=%b npv=%b npc=%h we=%b addr=%h data=%h busy=%b",
                     name, stall_o, flush_o, new_pc_valid_o, new_pc_o, csr_we_o, csr_waddr_o,
                     csr_wdata_o, busy_o);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        // id exe jmp trap mret jaddr          stall     flush   npv npc
        vecs[0] = mk(0, 0, 0, 0, 0, 32'h0,    5'b00000, 3'b000, 0, 32'h0);
        vecs[1] = mk(1, 0, 0, 0, 0, 32'h0,    5'b00011, 3'b010, 0, 32'h0);
        vecs[2] = mk(0, 1, 0, 0, 0, 32'h0,    5'b01111, 3'b100, 0, 32'h0);
        vecs[3] = mk(1, 1, 0, 0, 0, 32'h0,    5'b01111, 3'b100, 0, 32'h0);
        vecs[4] = mk(0, 0, 1, 0, 0, 32'h100,  5'b00000, 3'b011, 1, 32'h100);
        vecs[5] = mk(0, 1, 1, 0, 0, 32'h100,  5'b00000, 3'b011, 1, 32'h100);
        vecs[6] = mk(1, 0, 1, 0, 0, 32'h1234, 5'b00000, 3'b011, 1, 32'h1234);
        vecs[7] = mk(0, 1, 0, 1, 0, 32'h0,    5'b01111, 3'b100, 0, 32'h0);
        vecs[8] = mk(1, 1, 0, 0, 1, 32'h0,    5'b01111, 3'b100, 0, 32'h0);
        vecs[9] = mk(1, 0, 1, 0, 0, 32'h2468, 5'b00000, 3'b011, 1, 32'h2468);

        // Reset held with requests active: everything must read zero
        rst_n_i = 1'b0;
        clr_req();
        exe_jump_addr_i = 32'h44; trap_pc_i = '0; trap_cause_i = '0;
        mtvec_i = '0; mepc_i = '0; mstatus_i = '0;
        id_stallreq_i = 1'b1; exe_jump_i = 1'b1;
        #2;
        chk("reset_outputs", 5'b0, 3'b0, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        chk_val("reset_stall_cycles", stall_cycles_o, 32'h0);
        chk_val("reset_timeout", {31'b0, stall_timeout_o}, 32'h0);
        repeat (2) @(posedge clk_i);
        #3;
        clr_req();
        rst_n_i = 1'b1;

        // Single-cycle arbitration table
        sc_exp = 0;
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            chk_val($sformatf("cycles_before_v%0d", i), stall_cycles_o, sc_exp);
            id_stallreq_i   = vecs[i].id;
            exe_stallreq_i  = vecs[i].exe;
            exe_jump_i      = vecs[i].jump;
            trap_req_i      = vecs[i].trap;
            mret_req_i      = vecs[i].mret;
            exe_jump_addr_i = vecs[i].jaddr;
            #1;
            chk($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].npv,
                vecs[i].npc, 0, 12'h0, 32'h0, 0);
            sc_exp += int'(vecs[i].stall[0]);
        end
        next_cycle();
        chk_val("cycles_after_table", stall_cycles_o, sc_exp);

        // Trap entry with a same-cycle jump that must be dropped
        clr_req();
        trap_req_i = 1'b1; exe_jump_i = 1'b1; exe_jump_addr_i = 32'h999;
        trap_pc_i = 32'h80; trap_cause_i = 32'd11; mtvec_i = 32'h203; mstatus_i = 32'h8;
        #1;
        chk("trap_req", 5'b11111, 3'b000, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        next_cycle(); clr_req(); #1;
        chk("trap_mepc", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h341, 32'h80, 1);
        next_cycle(); #1;
        chk("trap_mcause", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h342, 32'd11, 1);
        next_cycle(); #1;
        chk("trap_mstatus", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h300, 32'h1880, 1);
        next_cycle(); #1;
        chk("trap_redirect", 5'b00000, 3'b111, 1, 32'h200, 0, 12'h0, 32'h0, 1);
        next_cycle(); #1;
        chk("trap_done", 5'b0, 3'b0, 0, 32'h0, 0, 12'h0, 32'h0, 0);

        // mret, with a trap pulse during busy that must be ignored
        mret_req_i = 1'b1; mepc_i = 32'h84; mstatus_i = 32'h80;
        #1;
        chk("mret_req", 5'b11111, 3'b000, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        next_cycle(); mret_req_i = 1'b0; trap_req_i = 1'b1; trap_pc_i = 32'h10; #1;
        chk("mret_mstatus", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h300, 32'h88, 1);
        next_cycle(); trap_req_i = 1'b0; #1;
        chk("mret_redirect", 5'b00000, 3'b111, 1, 32'h84, 0, 12'h0, 32'h0, 1);
        next_cycle(); #1;
        chk("mret_done", 5'b0, 3'b0, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        next_cycle(); #1;
        chk("mret_trap_ignored", 5'b0, 3'b0, 0, 32'h0, 0, 12'h0, 32'h0, 0);

        // Reset asserted during T_MCAUSE, then a full trap sequence restarts
        trap_req_i = 1'b1; trap_pc_i = 32'h3C; trap_cause_i = 32'd7;
        mtvec_i = 32'h100; mstatus_i = 32'h0;
        #1;
        chk("rst_trap_req", 5'b11111, 3'b000, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        next_cycle(); clr_req(); #1;
        chk("rst_trap_mepc", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h341, 32'h3C, 1);
        next_cycle(); #1;
        chk("rst_trap_mcause", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h342, 32'd7, 1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst_mid_fsm", 5'b0, 3'b0, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        chk_val("rst_mid_cycles", stall_cycles_o, 32'h0);
        @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        next_cycle();
        trap_req_i = 1'b1; trap_pc_i = 32'h40; trap_cause_i = 32'd3;
        #1;
        chk("restart_req", 5'b11111, 3'b000, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        next_cycle(); clr_req(); #1;
        chk("restart_mepc", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h341, 32'h40, 1);
        next_cycle(); #1;
        chk("restart_mcause", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h342, 32'd3, 1);
        next_cycle(); #1;
        chk("restart_mstatus", 5'b01111, 3'b111, 0, 32'h0, 1, 12'h300, 32'h1800, 1);
        next_cycle(); #1;
        chk("restart_redirect", 5'b00000, 3'b111, 1, 32'h100, 0, 12'h0, 32'h0, 1);
        next_cycle(); #1;
        chk("restart_done", 5'b0, 3'b0, 0, 32'h0, 0, 12'h0, 32'h0, 0);

        // Timeout: a broken run must not count, 64 consecutive cycles must
        exe_stallreq_i = 1'b1; id_stallreq_i = 1'b1;
        #1;
        chk("to_stall", 5'b01111, 3'b100, 0, 32'h0, 0, 12'h0, 32'h0, 0);
        for (int k = 0; k < 40; k++) next_cycle();
        clr_req();
        next_cycle();
        exe_stallreq_i = 1'b1; id_stallreq_i = 1'b1;
        for (int k = 0; k < 63; k++) next_cycle();
        chk_val("timeout_after_63", {31'b0, stall_timeout_o}, 32'h0);
        next_cycle();
        chk_val("timeout_after_64", {31'b0, stall_timeout_o}, 32'h1);
        clr_req();
        repeat (3) next_cycle();
        chk_val("timeout_sticky", {31'b0, stall_timeout_o}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
